// File: rtl/cflog_pkg.sv
// Shared types for the control-flow log flush controller: FSM states, cause codes, defaults.
package cflog_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NMI,
        ST_HDR,
        ST_READ,
        ST_SEND,
        ST_DONE
    } state_e;

    typedef logic [1:0] cause_t;

    localparam cause_t      CAUSE_NONE   = 2'b00;
    localparam cause_t      CAUSE_FLUSH  = 2'b01;
    localparam cause_t      CAUSE_ER     = 2'b10;
    localparam cause_t      CAUSE_BOOT   = 2'b11;
    localparam logic [15:0] LOG_SIZE_DEF = 16'h0080;
    localparam int          CNT_W_DEF    = 14;

    function automatic logic [15:0] sat_count(input logic [15:0] ptr, input logic [15:0] lim);
        return (ptr > lim) ? lim : ptr;
    endfunction

endpackage

// File: rtl/cflog_trig_arb.sv
// Trigger arbiter: remembers triggers seen while busy and hands out the highest-priority one in IDLE.
module cflog_trig_arb
    import cflog_pkg::*;
(
    input  logic   clk_i,
    input  logic   puc_i,
    input  logic   boot_i,
    input  logic   er_done_i,
    input  logic   flush_req_i,
    input  logic   idle_i,
    output logic   valid_o,
    output cause_t cause_o
);

    // Bit order {boot, er_done, flush} matches priority high to low.
    logic [2:0] pend_q, pend_d;
    logic [2:0] req;
    logic [2:0] gnt;

    assign req = pend_q | {boot_i, er_done_i, flush_req_i};

    always_comb begin
        gnt     = 3'b000;
        cause_o = CAUSE_NONE;
        if (req[2]) begin
            gnt     = 3'b100;
            cause_o = CAUSE_BOOT;
        end else if (req[1]) begin
            gnt     = 3'b010;
            cause_o = CAUSE_ER;
        end else if (req[0]) begin
            gnt     = 3'b001;
            cause_o = CAUSE_FLUSH;
        end
        pend_d = req & ~(idle_i ? gnt : 3'b000);
    end

    assign valid_o = idle_i && (req != 3'b000);

    always_ff @(posedge clk_i) begin
        if (puc_i) pend_q <= 3'b000;
        else       pend_q <= pend_d;
    end

endmodule

// File: rtl/cflog_flush_ctrl.sv
// Flush controller: raises an NMI, then streams a header and the log contents to the TX sink.
module cflog_flush_ctrl
    import cflog_pkg::*;
#(
    parameter logic [15:0] LOG_SIZE = LOG_SIZE_DEF,
    parameter int          CNT_W    = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        puc,
    input  logic        flush_req,
    input  logic        er_done,
    input  logic        boot,
    input  logic [15:0] log_ptr,
    input  logic        tcb_ack,
    output logic        log_rd_en,
    output logic [15:0] log_rd_addr,
    input  logic [15:0] log_rd_data,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        acfa_nmi,
    output logic        log_clear,
    output logic        busy
);

    state_e      state_q, state_d;
    cause_t      cause_q, cause_d;
    logic [15:0] count_q, count_d;
    logic [15:0] idx_q, idx_d;
    logic [15:0] tx_q, tx_d;
    logic        fresh_q, fresh_d;
    logic        trig_vld;
    cause_t      trig_cause;
    logic [15:0] hdr;

    cflog_trig_arb u_arb (
        .clk_i       (clk),
        .puc_i       (puc),
        .boot_i      (boot),
        .er_done_i   (er_done),
        .flush_req_i (flush_req),
        .idle_i      (state_q == ST_IDLE),
        .valid_o     (trig_vld),
        .cause_o     (trig_cause)
    );

    assign hdr  = 16'({cause_q, count_q[CNT_W-1:0]});
    assign busy = (state_q != ST_IDLE);
    // Read data is only valid in the first SEND cycle; pass it through then, hold the copy after.
    assign tx_data = (state_q == ST_SEND && fresh_q) ? log_rd_data : tx_q;

    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        count_d     = count_q;
        idx_d       = idx_q;
        tx_d        = tx_q;
        fresh_d     = 1'b0;
        acfa_nmi    = 1'b0;
        log_rd_en   = 1'b0;
        log_rd_addr = 16'h0000;
        log_clear   = 1'b0;
        tx_valid    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trig_vld) begin
                    cause_d = trig_cause;
                    count_d = sat_count(log_ptr, LOG_SIZE);
                    state_d = ST_NMI;
                end
            end
            ST_NMI: begin
                acfa_nmi = 1'b1;
                if (tcb_ack) begin
                    tx_d    = hdr;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                tx_valid = 1'b1;
                if (tx_ready) begin
                    idx_d   = 16'h0000;
                    state_d = (count_q == 16'h0000) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                log_rd_en   = 1'b1;
                log_rd_addr = idx_q;
                fresh_d     = 1'b1;
                state_d     = ST_SEND;
            end
            ST_SEND: begin
                tx_valid = 1'b1;
                if (fresh_q) tx_d = log_rd_data;
                if (tx_ready) begin
                    idx_d   = idx_q + 16'd1;
                    state_d = (idx_q == count_q - 16'd1) ? ST_DONE : ST_READ;
                end
            end
            ST_DONE: begin
                log_clear = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (puc) begin
            state_q <= ST_IDLE;
            cause_q <= CAUSE_NONE;
            count_q <= 16'h0000;
            idx_q   <= 16'h0000;
            tx_q    <= 16'h0000;
            fresh_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            fresh_q <= fresh_d;
        end
    end

endmodule

// File: tb/tb_cflog_flush_ctrl.sv
// Directed bench for cflog_flush_ctrl: log memory model, transfer monitor, immediate-assertion checks.
module tb_cflog_flush_ctrl;

    logic        clk = 1'b0;
    logic        puc, flush_req, er_done, boot, tcb_ack, tx_ready;
    logic [15:0] log_ptr, log_rd_data;
    logic        log_rd_en, tx_valid, acfa_nmi, log_clear, busy;
    logic [15:0] log_rd_addr, tx_data;

    int          n_vec = 0;
    int          n_err = 0;
    int          clr_cnt = 0;
    int          clr0;
    logic [15:0] q[$];
    logic [15:0] held;
    logic [15:0] exp3[3];
    int          bad;

    always #5 clk = ~clk;

    cflog_flush_ctrl dut (
        .clk         (clk),
        .puc         (puc),
        .flush_req   (flush_req),
        .er_done     (er_done),
        .boot        (boot),
        .log_ptr     (log_ptr),
        .tcb_ack     (tcb_ack),
        .log_rd_en   (log_rd_en),
        .log_rd_addr (log_rd_addr),
        .log_rd_data (log_rd_data),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .acfa_nmi    (acfa_nmi),
        .log_clear   (log_clear),
        .busy        (busy)
    );

    function automatic logic [15:0] mval(input int i);
        return 16'(32'hA500 + i * 7);
    endfunction

    // Log RAM: data valid exactly one cycle after the strobe, garbage otherwise.
    always @(posedge clk) log_rd_data <= log_rd_en ? mval(int'(log_rd_addr)) : 16'hDEAD;

    always @(negedge clk) begin
        if (!puc && tx_valid && tx_ready) q.push_back(tx_data);
        if (log_clear) clr_cnt <= clr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // trig bits {boot, er_done, flush_req}
    task automatic pulse(input logic [2:0] trig);
        {boot, er_done, flush_req} = trig;
        step();
        {boot, er_done, flush_req} = 3'b000;
    endtask

    task automatic run_ack();
        int k;
        k = 0;
        while (acfa_nmi !== 1'b1 && k < 20) begin step(); k++; end
        chk("nmi_seen", {busy, acfa_nmi}, 2'b11);
        repeat (2) step();
        chk("nmi_held", acfa_nmi, 1'b1);
        tcb_ack = 1'b1;
        step();
        tcb_ack = 1'b0;
        chk("nmi_drop", acfa_nmi, 1'b0);
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        while (tx_valid !== 1'b1 && k < 20) begin step(); k++; end
        chk(tag, tx_valid, 1'b1);
    endtask

    task automatic handshake();
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < budget) begin step(); k++; end
        chk(tag, busy, 1'b0);
    endtask

    initial begin
        puc = 1'b1; flush_req = 1'b0; er_done = 1'b0; boot = 1'b0;
        tcb_ack = 1'b0; tx_ready = 1'b1; log_ptr = 16'h0000;
        step(); step();
        chk("reset_outs", {tx_valid, acfa_nmi, log_clear, busy, log_rd_en, log_rd_addr, tx_data}, 64'h0);
        puc = 1'b0;
        step();
        chk("idle_after_reset", {busy, acfa_nmi}, 2'b00);

        // flush, 3 words, ready always high
        log_ptr = 16'd3; q.delete(); clr0 = clr_cnt;
        pulse(3'b001);
        run_ack();
        wait_idle("t1_idle", 40);
        chk("t1_len", q.size(), 4);
        chk("t1_hdr", q[0], 16'h4003);
        for (int i = 0; i < 3; i++) chk("t1_word", q[i+1], mval(i));
        chk("t1_clear", clr_cnt - clr0, 1);

        // boot and flush together with an empty log
        log_ptr = 16'd0; q.delete(); clr0 = clr_cnt;
        pulse(3'b101);
        run_ack();
        wait_idle("t2_gap", 40);
        run_ack();
        wait_idle("t2_idle", 40);
        chk("t2_len", q.size(), 2);
        chk("t2_hdr0", q[0], 16'hC000);
        chk("t2_hdr1", q[1], 16'h4000);
        chk("t2_clear", clr_cnt - clr0, 2);

        // er_done with 5-cycle stalls on every word
        log_ptr = 16'd2; q.delete(); tx_ready = 1'b0;
        exp3[0] = 16'h8002; exp3[1] = mval(0); exp3[2] = mval(1);
        pulse(3'b010);
        run_ack();
        for (int w = 0; w < 3; w++) begin
            wait_valid("t3_valid");
            held = tx_data;
            chk("t3_word", held, exp3[w]);
            for (int s = 0; s < 5; s++) begin
                step();
                chk("t3_stall", {tx_valid, log_rd_en, tx_data}, {1'b1, 1'b0, held});
            end
            handshake();
        end
        wait_idle("t3_idle", 20);
        chk("t3_len", q.size(), 3);
        tx_ready = 1'b1;

        // oversized log pointer saturates at LOG_SIZE
        log_ptr = 16'h0200; q.delete();
        pulse(3'b001);
        run_ack();
        wait_idle("t4_idle", 600);
        chk("t4_len", q.size(), 129);
        chk("t4_hdr", q[0], 16'h4080);
        bad = 0;
        for (int i = 1; i < q.size(); i++) if (q[i] !== mval(i - 1)) bad++;
        chk("t4_words", bad, 0);

        // reset in the middle of word 1, with a trigger pending
        log_ptr = 16'd3; q.delete(); tx_ready = 1'b0; clr0 = clr_cnt;
        pulse(3'b001);
        run_ack();
        wait_valid("t5_hdr");
        handshake();
        wait_valid("t5_w0");
        handshake();
        wait_valid("t5_w1");
        chk("t5_w1_data", tx_data, mval(1));
        pulse(3'b100);
        puc = 1'b1;
        step();
        chk("t5_reset_outs", {tx_valid, acfa_nmi, log_clear, busy, log_rd_en, log_rd_addr, tx_data}, 64'h0);
        puc = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t5_stay_idle", {busy, acfa_nmi, log_clear}, 3'b000);
        end
        chk("t5_no_clear", clr_cnt - clr0, 0);

        // flush arriving during SEND is serviced afterwards
        log_ptr = 16'd1; q.delete();
        pulse(3'b010);
        run_ack();
        wait_valid("t6_hdr");
        handshake();
        wait_valid("t6_w0");
        pulse(3'b001);
        tx_ready = 1'b1;
        wait_idle("t6_gap", 20);
        run_ack();
        wait_idle("t6_idle", 20);
        chk("t6_len", q.size(), 4);
        chk("t6_hdr0", q[0], 16'h8001);
        chk("t6_w0", q[1], mval(0));
        chk("t6_hdr1", q[2], 16'h4001);
        chk("t6_w1", q[3], mval(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cflog_flush_ctrl.md
CFLOG_FLUSH_CTRL -- requirements
Module: cflog_flush_ctrl

Interface
REQ-001 Parameter LOG_SIZE, default 16'h0080, log capacity in 2-byte words.
REQ-002 Parameter CNT_W, default 14, header count-field width.
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 puc  in  1  reset; synchronous, active-high.
REQ-005 flush_req  in  1  log-full trigger, level.
REQ-006 er_done  in  1  ER-completion trigger, level.
REQ-007 boot  in  1  boot trigger, level.
REQ-008 log_ptr  in  16  number of valid log words.
REQ-009 tcb_ack  in  1  TCB has taken the NMI (pc at TCB entry).
REQ-010 log_rd_en  out  1  log read strobe.
REQ-011 log_rd_addr  out  16  log word index.
REQ-012 log_rd_data  in  16  read data, valid exactly 1 cycle after log_rd_en.
REQ-013 tx_data  out  16  outbound word.
REQ-014 tx_valid  out  1  outbound word valid.
REQ-015 tx_ready  in  1  sink accepts; transfer when tx_valid and tx_ready.
REQ-016 acfa_nmi  out  1  NMI request to core.
REQ-017 log_clear  out  1  one-cycle pulse: log pointer returns to 0.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 FSM states SHALL be IDLE, NMI, HDR, READ, SEND, DONE.
REQ-020 Trigger priority SHALL be boot > er_done > flush_req; cause codes boot=2'b11, er_done=2'b10, flush=2'b01.
REQ-021 In IDLE, a trigger sampled at cycle N SHALL latch cause and count=min(log_ptr, LOG_SIZE) and enter NMI at N+1.
REQ-022 Triggers asserted while not in IDLE SHALL set a per-cause pending bit; pending bits are serviced by priority as triggers on return to IDLE; servicing a cause clears its bit.
REQ-023 acfa_nmi SHALL be high in NMI only; tcb_ack high in NMI moves to HDR next cycle; no timeout.
REQ-024 In HDR tx_data SHALL be {cause, count[CNT_W-1:0]} with tx_valid high until transfer.
REQ-025 After header transfer: count==0 -> DONE, else READ with idx=0.
REQ-026 READ SHALL last one cycle: log_rd_en=1, log_rd_addr=idx; then SEND.
REQ-027 On entering SEND tx_data SHALL capture log_rd_data and stay stable with tx_valid high until transfer.
REQ-028 On SEND transfer idx increments; idx==count-1 -> DONE, else READ.
REQ-029 DONE SHALL last one cycle with log_clear=1, then IDLE.
REQ-030 tx_data, tx_valid, log_rd_en SHALL never change while tx_valid high and tx_ready low, except by puc.
REQ-031 idx and count arithmetic SHALL be 16-bit unsigned; log_ptr > LOG_SIZE saturates to LOG_SIZE.

Reset
REQ-032 puc SHALL force IDLE, clear cause, count, idx, pending bits and tx_data in the same edge.
REQ-033 During and after reset all outputs SHALL be 0; puc mid-operation SHALL NOT emit log_clear.

Structure
REQ-034 Package cflog_pkg SHALL hold the state enum, cause encodings and LOG_SIZE default.
REQ-035 Trigger latching and priority selection SHALL be sub-module cflog_trig_arb; FSM, counters and datapath stay in cflog_flush_ctrl.

Verification
REQ-036 flush_req at log_ptr=3, tcb_ack 2 cycles after NMI, tx_ready=1 -> header 16'h4003, words 0..2 in order, one log_clear, busy low after.
REQ-037 boot and flush_req same cycle, log_ptr=0 -> header 16'hC000 only, then flush serviced: second header 16'h4000.
REQ-038 er_done, log_ptr=2, tx_ready low 5 cycles per word -> tx_data/tx_valid stable throughout stall, header 16'h8002.
REQ-039 log_ptr=16'h0200 on flush_req -> header count 16'h0080, exactly 128 data words.
REQ-040 puc asserted during SEND of word 1 -> next cycle all outputs 0, no log_clear, state IDLE, pending cleared.
REQ-041 flush_req pulsed while in SEND -> after DONE, new NMI cycle starts with cause 2'b01.
